// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one tick-driven UART byte transmitter between
// NUM_REQ packet producers, holding each grant for a whole packet or until a stall timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int IdW  = $clog2(NUM_REQ);
  localparam int CntW = $clog2(TIMEOUT);
  localparam logic [IdW-1:0]  LastReset = IdW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] StallMax  = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic [IdW-1:0]  last_grant_q, last_grant_d;
  logic            grant_active_q, grant_active_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            timeout_err_q, timeout_err_d;
  logic            pkt_last_q, pkt_last_d;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

  logic            pick_valid;
  logic [IdW-1:0]  pick_id;
  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_data;

  // First valid requester scanning upward from the one after the most recent owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = last_grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pick_valid && req_valid[i] && (i == (int'(last_grant_q) + k) % NUM_REQ)) begin
          pick_valid = 1'b1;
          pick_id    = IdW'(i);
        end
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IdW'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    grant_active_d = grant_active_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    timeout_err_d  = 1'b0;
    pkt_last_d     = pkt_last_q;
    stall_cnt_d    = stall_cnt_q;
    req_ready      = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d     = pick_id;
          grant_active_d = 1'b1;
          stall_cnt_d    = '0;
          state_d        = SEND;
        end
      end
      SEND: begin
        req_ready[grant_id_q] = !tx_busy;
        if (owner_valid && !tx_busy) begin
          tx_data_d  = owner_data;
          pkt_last_d = owner_last;
          tx_start_d = 1'b1;
          state_d    = WAIT;
        end else if (stall_cnt_q == StallMax) begin
          // The partial packet is dropped; the rest of it is never sent.
          timeout_err_d  = 1'b1;
          grant_active_d = 1'b0;
          last_grant_d   = grant_id_q;
          state_d        = IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + CntW'(1);
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (pkt_last_q) begin
            grant_active_d = 1'b0;
            last_grant_d   = grant_id_q;
            state_d        = IDLE;
          end else begin
            stall_cnt_d = '0;
            state_d     = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= LastReset;
      grant_active_q <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      timeout_err_q  <= 1'b0;
      pkt_last_q     <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      grant_active_q <= grant_active_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      timeout_err_q  <= timeout_err_d;
      pkt_last_q     <= pkt_last_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level round-robin model predicts
// the byte/owner order, and a monitor checks every tx_start and timeout_err against it.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;
  localparam int IDW     = $clog2(NUM_REQ);

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 grant_active;
  logic [IDW-1:0]       grant_id;
  logic                 timeout_err;

  logic txBusyModel;
  logic busyForce;
  assign tx_busy = txBusyModel | busyForce;

  typedef struct {
    int         id;
    logic [7:0] data;
  } byte_t;

  byte_t        expQ[$];
  int           expTimeoutQ[$];
  logic [8:0]   reqQ[NUM_REQ][$];
  logic [7:0]   pendBytes[NUM_REQ][$];
  int           pendLen[NUM_REQ][$];
  int           modelLast;
  logic [NUM_REQ-1:0] accSample = '0;

  int    testsRun    = 0;
  int    testsFailed = 0;
  int    cyc         = 0;
  int    lastDoneCyc = 0;
  int    frameFixed  = 0;
  int    txLen;
  int    txExtra;
  byte_t monByte;
  int    monId;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_active(grant_active),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queue one packet on a requester; startByte < 0 gives random bytes.
  task automatic applyStimulus(input int id, input int len, input int startByte);
    logic [7:0] b;
    for (int j = 0; j < len; j++) begin
      b = (startByte < 0) ? 8'($urandom) : 8'(startByte + j);
      reqQ[id].push_back({(j == len - 1), b});
      pendBytes[id].push_back(b);
    end
    pendLen[id].push_back(len);
  endtask

  // Packet-level round robin over everything currently pending.
  task automatic modelArbitrate();
    int  pick;
    int  len;
    bit  found;
    forever begin
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= NUM_REQ && !found; k++) begin
        pick = (modelLast + k) % NUM_REQ;
        if (pendLen[pick].size() > 0) found = 1'b1;
      end
      if (!found) break;
      len = pendLen[pick].pop_front();
      repeat (len) expQ.push_back('{id: pick, data: pendBytes[pick].pop_front()});
      modelLast = pick;
    end
  endtask

  function automatic bit driversEmpty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (reqQ[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic waitIdle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (expQ.size() == 0 && expTimeoutQ.size() == 0 && grant_active === 1'b0 &&
          tx_busy === 1'b0 && driversEmpty()) done = 1'b1;
    end
    if (!done) begin
      checkOutput("waitIdle pending expectations", expQ.size() + expTimeoutQ.size(), 0);
      expQ.delete();
      expTimeoutQ.delete();
      for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic waitTxStart(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("waitTxStart budget", tx_start, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " grant_active"}, grant_active, 0);
    checkOutput({tag, " grant_id"}, grant_id, 0);
    checkOutput({tag, " tx_start"}, tx_start, 0);
    checkOutput({tag, " tx_data"}, tx_data, 0);
    checkOutput({tag, " timeout_err"}, timeout_err, 0);
    checkOutput({tag, " req_ready"}, req_ready, 0);
  endtask

  initial forever begin
    @(negedge clk);
    accSample = req_valid & req_ready;
  end

  // Requesters present their queued bytes continuously until accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accSample[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        if (reqQ[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = reqQ[i][0][7:0];
          req_last[i]        = reqQ[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter: busy for the frame, tx_done txLen cycles after tx_start, then a
  // few random trailing busy cycles to exercise backpressure in SEND.
  initial begin
    txBusyModel = 1'b0;
    tx_done     = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && reset !== 1'b1) begin
        txLen   = (frameFixed > 0) ? frameFixed : int'($urandom_range(12, 4));
        txExtra = (frameFixed > 0) ? 0 : int'($urandom_range(3, 0));
        @(posedge clk);
        #1 txBusyModel = 1'b1;
        for (int k = 1; k < txLen && reset !== 1'b1; k++) begin
          @(posedge clk);
          #1;
        end
        if (reset !== 1'b1) begin
          tx_done     = 1'b1;
          lastDoneCyc = cyc;
          @(posedge clk);
          #1 tx_done = 1'b0;
        end
        for (int k = 0; k < txExtra && reset !== 1'b1; k++) begin
          @(posedge clk);
          #1;
        end
        txBusyModel = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1) begin
      if (tx_start === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected tx_start", tx_start, 0);
        end else begin
          monByte = expQ.pop_front();
          checkOutput("tx_data", tx_data, monByte.data);
          checkOutput("grant_id at tx_start", grant_id, monByte.id);
          checkOutput("grant_active at tx_start", grant_active, 1);
        end
      end
      if (timeout_err === 1'b1) begin
        if (expTimeoutQ.size() == 0) begin
          checkOutput("unexpected timeout_err", timeout_err, 0);
        end else begin
          monId = expTimeoutQ.pop_front();
          checkOutput("grant_id at timeout", grant_id, monId);
          checkOutput("grant_active at timeout", grant_active, 0);
          checkOutput("timeout latency from tx_done", cyc - lastDoneCyc, TIMEOUT + 1);
        end
      end
      if (tx_busy === 1'b1) checkOutput("req_ready while tx_busy", req_ready, 0);
    end
  end

  initial begin
    reset     = 1'b1;
    busyForce = 1'b0;
    modelLast = NUM_REQ - 1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    // Round robin from reset: 0, 1, 3, then 0 again after wrapping.
    applyStimulus(0, 1, 8'h10);
    applyStimulus(1, 1, 8'h11);
    applyStimulus(3, 1, 8'h13);
    modelArbitrate();
    waitIdle(1000);
    applyStimulus(0, 1, 8'h20);
    modelArbitrate();
    waitIdle(1000);

    // Requester 0 arrives while 1 is mid-packet and must wait for the packet end.
    applyStimulus(1, 3, 8'h51);
    modelArbitrate();
    waitTxStart(100);
    applyStimulus(0, 1, 8'h50);
    modelArbitrate();
    waitIdle(1000);

    // Two-byte packet on requester 2 with 160-cycle frames.
    frameFixed = 160;
    applyStimulus(2, 2, 8'h41);
    modelArbitrate();
    for (int n = 0; n < 1000 && expQ.size() != 0; n++) @(negedge clk);
    for (int n = 0; n < 300 && tx_done !== 1'b1; n++) @(negedge clk);
    checkOutput("tx_done seen for last byte", tx_done, 1);
    checkOutput("grant_active at last tx_done", grant_active, 1);
    checkOutput("grant_id during packet", grant_id, 2);
    @(negedge clk);
    checkOutput("grant_active after last tx_done", grant_active, 0);
    checkOutput("grant_id holds in IDLE", grant_id, 2);
    waitIdle(400);
    frameFixed = 0;

    // Backpressure: tx_busy held in SEND keeps req_ready low until it drops.
    busyForce = 1'b1;
    applyStimulus(3, 1, 8'h77);
    modelArbitrate();
    repeat (8) @(negedge clk);
    checkOutput("req_ready under forced busy", req_ready, 0);
    @(posedge clk);
    #1 busyForce = 1'b0;
    #1 checkOutput("req_ready same cycle busy drops", req_ready, 4'b1000);
    waitIdle(1000);

    // Timeout: requester 2 stops after a non-last byte; requester 3 takes over.
    reqQ[2].push_back({1'b0, 8'hA0});
    expQ.push_back('{id: 2, data: 8'hA0});
    expTimeoutQ.push_back(2);
    modelLast = 2;
    waitTxStart(100);
    applyStimulus(3, 1, 8'h33);
    modelArbitrate();
    waitIdle(1000);

    // Randomized rounds of packets across all requesters.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        repeat ($urandom_range(2, 0)) applyStimulus(i, int'($urandom_range(4, 1)), -1);
      end
      modelArbitrate();
      waitIdle(3000);
    end

    // Reset while a frame is in flight, then requester 0 wins first.
    applyStimulus(1, 1, 8'h99);
    modelArbitrate();
    waitTxStart(100);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkResetValues("async reset mid-WAIT");
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    modelLast = NUM_REQ - 1;
    repeat (2) @(negedge clk);
    applyStimulus(2, 1, 8'hB2);
    applyStimulus(0, 1, 8'hB0);
    modelArbitrate();
    waitIdle(1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
